// File: rtl/punc_mem_arbiter.sv
// Round-robin arbiter sharing the PUnC data-memory port between the core (port 0)
// and the loader/debug port (port 1), with ownership lock for two-access sequences.
//
// state | meaning
// IDLE  | no owner; round-robin between requesters using last
// LOCK0 | port 0 owns the memory until an unlocked port 0 access
// LOCK1 | port 1 owns the memory until an unlocked port 1 access
module punc_mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_w_en,
    output logic [DW-1:0] mem_w_data,
    input  logic [DW-1:0] mem_r_data,
    output logic          core_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        state;
    logic          last;
    logic [DW-1:0] rdata_q;
    logic          rd_gnt;

    // Unused encoding arbitrates like IDLE so a corrupted state cannot starve both ports.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            LOCK0: gnt0 = req0;
            LOCK1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    gnt0 = last;
                    gnt1 = ~last;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

    assign mem_addr   = gnt1 ? addr1 : addr0;
    assign mem_w_data = gnt1 ? wdata1 : wdata0;
    assign mem_w_en   = rst & ((gnt0 & we0) | (gnt1 & we1));
    assign core_stall = req0 & ~gnt0;
    assign rd_gnt     = (gnt0 & ~we0) | (gnt1 & ~we1);
    assign rdata0     = rdata_q;
    assign rdata1     = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            rdata_q <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (rd_gnt) begin
                rdata_q <= mem_r_data;
            end
            if (gnt0) begin
                last  <= 1'b0;
                state <= lock0 ? LOCK0 : IDLE;
            end else if (gnt1) begin
                last  <= 1'b1;
                state <= lock1 ? LOCK1 : IDLE;
            end else if (state != LOCK0 && state != LOCK1) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed bench for punc_mem_arbiter: per-cycle grant/memory-drive checks plus a
// read-data scoreboard fed at grant time and drained when rvalid appears.
module tb_punc_mem_arbiter;

    localparam logic [15:0] PAT = 16'h5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_w_en, core_stall;
    logic [15:0] rdata0, rdata1, mem_addr, mem_w_data, mem_r_data;

    logic [15:0] mem [0:65535];

    typedef struct {
        logic        port;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic prv0 = 1'b0;
    logic prv1 = 1'b0;

    punc_mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data), .core_stall(core_stall)
    );

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_addr];
    always @(posedge clk) if (mem_w_en) mem[mem_addr] = mem_w_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    endtask

    // One clock cycle: check combinational outputs at negedge, queue read data, advance.
    task automatic step(input string tag, input logic eg0, input logic eg1, input logic [15:0] edata);
        @(negedge clk);
        chk({tag, "_gnt0"}, 32'(gnt0), 32'(eg0));
        chk({tag, "_gnt1"}, 32'(gnt1), 32'(eg1));
        chk({tag, "_stall"}, 32'(core_stall), 32'(req0 & ~eg0));
        chk({tag, "_wen"}, 32'(mem_w_en), 32'((eg0 & we0) | (eg1 & we1)));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(eg1 ? addr1 : addr0));
        if (eg0 | eg1) chk({tag, "_wdata"}, 32'(mem_w_data), 32'(eg1 ? wdata1 : wdata0));
        chk({tag, "_rv0"}, 32'(rvalid0), 32'(prv0));
        chk({tag, "_rv1"}, 32'(rvalid1), 32'(prv1));
        prv0 = eg0 & ~we0;
        prv1 = eg1 & ~we1;
        if (prv0 | prv1) exp_q.push_back('{port: prv1, data: edata});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && (rvalid0 || rvalid1)) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                automatic exp_t e = exp_q.pop_front();
                chk("sb_port", 32'(rvalid1), 32'(e.port));
                chk("sb_rdata0", 32'(rdata0), 32'(e.data));
                chk("sb_rdata1", 32'(rdata1), 32'(e.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ PAT;
        mem[16'h3000] = 16'h1234;
        rst = 1'b0;
        idle();
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rv0", 32'(rvalid0), 32'(0));
        chk("rst_rv1", 32'(rvalid1), 32'(0));
        chk("rst_rdata", 32'(rdata0), 32'(0));
        rst = 1'b1;

        // Single core read
        req0 = 1'b1; addr0 = 16'h3000;
        step("t1_rd", 1'b1, 1'b0, 16'h1234);
        idle();
        step("t1_ret", 1'b0, 1'b0, 16'h0);

        // Loader write then core read-back
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 16'hBEEF;
        step("t4_wr", 1'b0, 1'b1, 16'h0);
        idle();
        step("t4_gap", 1'b0, 1'b0, 16'h0);
        req0 = 1'b1; addr0 = 16'h0010;
        step("t4_rd", 1'b1, 1'b0, 16'hBEEF);
        idle();
        step("t4_ret", 1'b0, 1'b0, 16'h0);

        // Re-reset so the conflict sequence starts from last = 1
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Continuous conflict alternates 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; addr0 = 16'h0200 + 16'(i);
            req1 = 1'b1; addr1 = 16'h0300 + 16'(i);
            step($sformatf("t2_c%0d", i), (i % 2) == 0, (i % 2) == 1,
                 ((i % 2) == 0 ? addr0 : addr1) ^ PAT);
        end

        // Core LDI holds port 1 off until the unlocked access completes
        req0 = 1'b1; lock0 = 1'b1; addr0 = 16'h0400;
        req1 = 1'b1; addr1 = 16'h0500;
        step("t3_ldi_a", 1'b1, 1'b0, 16'h0400 ^ PAT);
        req0 = 1'b0; lock0 = 1'b0;
        step("t3_gap", 1'b0, 1'b0, 16'h0);
        req0 = 1'b1; addr0 = 16'h0401;
        step("t3_ldi_b", 1'b1, 1'b0, 16'h0401 ^ PAT);
        req0 = 1'b0;
        step("t3_p1", 1'b0, 1'b1, 16'h0500 ^ PAT);
        idle();
        step("t3_ret", 1'b0, 1'b0, 16'h0);

        // Asynchronous reset while port 1 holds the lock with rvalid1 high
        req1 = 1'b1; lock1 = 1'b1; addr1 = 16'h0600;
        step("t5_lock1", 1'b0, 1'b1, 16'h0600 ^ PAT);
        idle();
        chk("t5_rv1_pre", 32'(rvalid1), 32'(1));
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        prv0 = 1'b0; prv1 = 1'b0;
        #1;
        chk("t5_rv1_async", 32'(rvalid1), 32'(0));
        chk("t5_rdata_async", 32'(rdata1), 32'(0));
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1111;
        req1 = 1'b1; addr1 = 16'h0021;
        #1;
        chk("t5_rst_gnt0", 32'(gnt0), 32'(1));
        chk("t5_rst_wen", 32'(mem_w_en), 32'(0));
        @(posedge clk);
        #1;
        chk("t5_rst_nowrite", 32'(mem[16'h0020]), 32'(16'h0020 ^ PAT));
        idle();
        rst = 1'b1;

        // First conflict after reset goes to port 0, then port 1
        req0 = 1'b1; addr0 = 16'h0700;
        req1 = 1'b1; addr1 = 16'h0701;
        step("t5_post0", 1'b1, 1'b0, 16'h0700 ^ PAT);
        step("t5_post1", 1'b0, 1'b1, 16'h0701 ^ PAT);
        idle();
        step("t5_ret", 1'b0, 1'b0, 16'h0);
        step("t5_quiet", 1'b0, 1'b0, 16'h0);

        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/punc_mem_arbiter.md
# punc_mem_arbiter

Two-port arbiter that shares the PUnC single data-memory port between the core (port 0: fetch, LD/LDR/LDI, ST/STR/STI) and an external loader/debug port (port 1). It sits between the core's memory-address/data muxes and the memory macro. Arbitration is round-robin. A lock holds ownership across indirect (LDI/STI) two-access sequences. Read data is returned registered, one cycle after grant.

## Interface
- AW, 16, address width
- DW, 16, data width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low; clears all state immediately
- req0 / req1  input  1  access request, port 0 (core) / port 1 (loader)
- we0 / we1  input  1  1 = write, 0 = read; valid with req
- lock0 / lock1  input  1  keep ownership after this access; valid with req
- addr0 / addr1  input  AW  access address
- wdata0 / wdata1  input  DW  write data
- gnt0 / gnt1  output  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  output  1  read data valid (registered)
- rdata0 / rdata1  output  DW  read data, both driven from one shared register
- mem_addr  output  AW  memory read/write address
- mem_w_en  output  1  memory write enable
- mem_w_data  output  DW  memory write data
- mem_r_data  input  DW  memory read data, combinational from mem_addr
- core_stall  output  1  req0 & ~gnt0; core control FSM holds its state while high

## Operation
- FSM states: IDLE, LOCK0, LOCK1. A 1-bit register last holds the last granted port. Output register rdata_q; registered flags rvalid0/rvalid1.
- Grant selection in IDLE:
  - Only one req high: that port is granted.
  - Both high: the port != last is granted.
  - Neither high: no grant.
- Grant selection in LOCKn: only port n can be granted. The other port's req is ignored and waits; it is never dropped.
- Transitions on a grant to port n:
  - lockn = 1: next state LOCKn.
  - lockn = 0: next state IDLE.
  - last <= n.
- LOCKn with reqn = 0: stays in LOCKn. Ownership is released only by a granted access with lockn = 0.
- Memory drive:
  - mem_addr = addr of the granted port. With no grant, mem_addr = addr0.
  - mem_w_data = wdata of the granted port.
  - mem_w_en = grant & we of the granted port. It is never high without a grant.
- Read return: on a granted read, rdata_q <= mem_r_data at the clock edge and rvalid of that port is high for exactly the next cycle. rdata0 = rdata1 = rdata_q.
- A granted write produces no rvalid.
- At most one gnt is high per cycle. gnt0 & gnt1 = 0 always.

## Timing
- Grant: same cycle as req (combinational from req, lock, state, last).
- Read latency: 1 cycle from grant to rvalid/rdata. Back-to-back reads by the same port are allowed every cycle.
- Write: committed at the granting clock edge.
- Reset (rst low, asynchronous, any time including mid-lock):
  - state = IDLE, last = 1 (port 0 wins the first conflict).
  - rdata_q = 0, rvalid0 = rvalid1 = 0.
  - Combinational outputs follow the inputs while in reset; mem_w_en is forced 0 while rst is low.
- Simultaneous events:
  - In IDLE, the conflict winner is decided by last only. lock has no effect on who wins.
  - A lock release and a new request from the other port in the same cycle: the other port is grantable on the next cycle.
- Fairness: with both ports requesting continuously without lock, grants alternate every cycle.

## Test plan
- Reset then req0 = 1, we0 = 0, addr0 = 16'h3000, memory[3000] = 16'h1234 -> gnt0 same cycle, rvalid0 = 1 and rdata0 = 16'h1234 next cycle, rvalid1 = 0.
- req0 and req1 both high for 4 cycles, no lock -> grant order 0, 1, 0, 1; core_stall high on cycles 2 and 4.
- Port 0 LDI: read with lock0 = 1, then an idle cycle, then read with lock0 = 0, while req1 is held high -> gnt1 stays 0 until the cycle after the unlocked access, then gnt1 = 1.
- Port 1 write, req1 = 1, we1 = 1, addr1 = 16'h0010, wdata1 = 16'hBEEF -> mem_w_en = 1 and mem_addr = 16'h0010 in that cycle only; a subsequent port 0 read of 16'h0010 returns 16'hBEEF.
- rst driven low mid-cycle while in LOCK1 with rvalid1 high -> rvalid1 drops immediately without a clock edge; after release, the first conflict is granted to port 0.
